// File: rtl/data_array_ctrl.sv
// Arbitration and sequencing for the single-port 16x256 cache data array: CPU port 0, fill port 1.
// Define DATA_ARRAY_CTRL_INIT_EN to zero-clear the whole array after reset before accepting traffic.
`timescale 1ns/1ps
module data_array_ctrl #(
    parameter int DATA_WIDTH = 256,
    parameter int NUM_WMASKS = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_p0_req,
    input  logic                  i_p0_we,
    input  logic [ADDR_WIDTH-1:0] i_p0_addr,
    input  logic [NUM_WMASKS-1:0] i_p0_wmask,
    input  logic [DATA_WIDTH-1:0] i_p0_wdata,
    output logic                  o_p0_gnt,
    output logic                  o_p0_rvalid,
    input  logic                  i_p1_req,
    input  logic                  i_p1_we,
    input  logic [ADDR_WIDTH-1:0] i_p1_addr,
    input  logic [NUM_WMASKS-1:0] i_p1_wmask,
    input  logic [DATA_WIDTH-1:0] i_p1_wdata,
    output logic                  o_p1_gnt,
    output logic                  o_p1_rvalid,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_ready,
    output logic                  o_sram_csb,
    output logic                  o_sram_web,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic [NUM_WMASKS-1:0] o_sram_wmask,
    output logic [DATA_WIDTH-1:0] o_sram_din,
    input  logic [DATA_WIDTH-1:0] i_sram_dout
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    logic              r_ready;
    logic              r_p0Rvalid;
    logic              r_p1Rvalid;
    logic [WAIT_W-1:0] r_waitCnt;
    logic              w_inRun;
    logic              w_readyNext;
    logic              w_sweep;
    logic              w_p1Urgent;
    logic              w_p0Gnt;
    logic              w_p1Gnt;

`ifdef DATA_ARRAY_CTRL_INIT_EN
    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [ADDR_WIDTH-1:0] r_sweepIdx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_INIT;
            r_sweepIdx <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_INIT) begin
                r_sweepIdx <= r_sweepIdx + ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (r_state == S_INIT && r_sweepIdx == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
            w_nextState = S_RUN;
        end
    end

    // Gating with rst_n keeps the SRAM deselected while reset is held, even though INIT is the reset state.
    assign w_inRun     = (r_state == S_RUN);
    assign w_readyNext = (w_nextState == S_RUN);
    assign w_sweep     = (r_state == S_INIT) && rst_n;
`else
    assign w_inRun     = 1'b1;
    assign w_readyNext = 1'b1;
    assign w_sweep     = 1'b0;
`endif

    // Port 1 overrides port 0 only once it has been starved for MAX_WAIT cycles.
    assign w_p1Urgent = i_p1_req && (r_waitCnt == WAIT_LIMIT);
    assign w_p1Gnt    = r_ready && i_p1_req && (w_p1Urgent || !i_p0_req);
    assign w_p0Gnt    = r_ready && i_p0_req && !w_p1Urgent;

    assign o_p0_gnt    = w_p0Gnt;
    assign o_p1_gnt    = w_p1Gnt;
    assign o_p0_rvalid = r_p0Rvalid;
    assign o_p1_rvalid = r_p1Rvalid;
    assign o_ready     = r_ready;
    assign o_rdata     = i_sram_dout;

    always_comb begin
        o_sram_csb   = 1'b1;
        o_sram_web   = 1'b1;
        o_sram_addr  = '0;
        o_sram_wmask = '0;
        o_sram_din   = '0;
        if (w_sweep) begin
            o_sram_csb   = 1'b0;
            o_sram_web   = 1'b0;
            o_sram_wmask = '1;
`ifdef DATA_ARRAY_CTRL_INIT_EN
            o_sram_addr  = r_sweepIdx;
`endif
        end else if (w_p0Gnt) begin
            o_sram_csb   = 1'b0;
            o_sram_web   = !i_p0_we;
            o_sram_addr  = i_p0_addr;
            o_sram_wmask = i_p0_we ? i_p0_wmask : '0;
            o_sram_din   = i_p0_wdata;
        end else if (w_p1Gnt) begin
            o_sram_csb   = 1'b0;
            o_sram_web   = !i_p1_we;
            o_sram_addr  = i_p1_addr;
            o_sram_wmask = i_p1_we ? i_p1_wmask : '0;
            o_sram_din   = i_p1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready    <= 1'b0;
            r_p0Rvalid <= 1'b0;
            r_p1Rvalid <= 1'b0;
            r_waitCnt  <= '0;
        end else begin
            r_ready    <= w_readyNext;
            r_p0Rvalid <= w_p0Gnt && !i_p0_we;
            r_p1Rvalid <= w_p1Gnt && !i_p1_we;
            if (!w_inRun || !i_p1_req || w_p1Gnt) begin
                r_waitCnt <= '0;
            end else if (r_waitCnt != WAIT_LIMIT) begin
                r_waitCnt <= r_waitCnt + WAIT_W'(1);
            end
        end
    end

endmodule
